// File: rtl/wishbone_nn_engine.sv
// Wishbone-slave neural layer engine.
// Holds inputs, weights and biases in registers and evaluates every neuron of one layer
// sequentially: a multiply-accumulate per cycle, then one store cycle per neuron with
// optional ReLU. The register file and the control/status block share one Wishbone port.
module wishbone_nn_engine #(
  parameter int unsigned N_INPUTS  = 8,
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);

  localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_INPUTS) + 1;
  localparam int unsigned N_W   = N_INPUTS * N_NEURONS;
  localparam int unsigned IW    = $clog2(N_INPUTS);
  localparam int unsigned NW    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned KW    = $clog2(N_W);

  // Register map expressed as word indices (byte offset >> 2).
  localparam logic [9:0] WCtrl   = 10'h000;
  localparam logic [9:0] WStatus = 10'h001;
  localparam logic [9:0] WBias   = 10'h020;
  localparam logic [9:0] WX      = 10'h040;
  localparam logic [9:0] WRes    = 10'h0C0;
  localparam logic [9:0] WW      = 10'h100;

  typedef enum logic [1:0] {StIdle, StMac, StStore} state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] x_q      [N_INPUTS];
  logic signed [DATA_W-1:0] w_q      [N_W];
  logic signed [DATA_W-1:0] bias_q   [N_NEURONS];
  logic signed [ACC_W-1:0]  result_q [N_NEURONS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [IW-1:0]            i_q;
  logic [NW-1:0]            n_q;
  logic [KW-1:0]            k_q;
  logic                     busy_q, done_q, relu_en_q, irq_en_q;
  logic                     ack_q;
  logic [31:0]              dat_q;

  logic                     hit, req, wr_ok;
  logic [9:0]               widx;
  logic signed [DATA_W-1:0] wdata;
  logic [31:0]              rdata;
  logic signed [2*DATA_W-1:0] prod;
  logic [NW-1:0]            n_nxt;
  logic                     unused;

  assign hit   = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req   = wbs_stb_i & wbs_cyc_i & hit;
  assign widx  = wbs_adr_i[11:2];
  assign wdata = wbs_dat_i[DATA_W-1:0];
  // Writes commit on the edge that ends the ack cycle, while the master still holds the bus.
  assign wr_ok = ack_q & req & wbs_we_i & (wbs_sel_i == 4'hF);
  assign prod  = x_q[i_q] * w_q[k_q];
  assign n_nxt = n_q + NW'(1);

  assign unused = ^{wbs_adr_i[1:0], wbs_dat_i[31:DATA_W]};

  // Read mux: decoded word index to sign-extended register contents, 0 when unmapped.
  always_comb begin
    rdata = '0;
    if (widx == WCtrl)   rdata = {29'b0, irq_en_q, relu_en_q, 1'b0};
    if (widx == WStatus) rdata = {30'b0, done_q, busy_q};
    for (int unsigned j = 0; j < N_NEURONS; j++) begin
      if (widx == WBias + 10'(j)) rdata = 32'(bias_q[j]);
      if (widx == WRes + 10'(j))  rdata = 32'(result_q[j]);
    end
    for (int unsigned j = 0; j < N_INPUTS; j++) begin
      if (widx == WX + 10'(j)) rdata = 32'(x_q[j]);
    end
    for (int unsigned j = 0; j < N_W; j++) begin
      if (widx == WW + 10'(j)) rdata = 32'(w_q[j]);
    end
  end

  // Bus handshake: ack one cycle after a request, never two cycles in a row.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req & ~ack_q;
      dat_q <= (req & ~ack_q) ? rdata : '0;
    end
  end

  // Operand register file; frozen while a computation is running.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned j = 0; j < N_INPUTS; j++)  x_q[j]    <= '0;
      for (int unsigned j = 0; j < N_W; j++)       w_q[j]    <= '0;
      for (int unsigned j = 0; j < N_NEURONS; j++) bias_q[j] <= '0;
    end else if (wr_ok && !busy_q) begin
      for (int unsigned j = 0; j < N_INPUTS; j++) begin
        if (widx == WX + 10'(j)) x_q[j] <= wdata;
      end
      for (int unsigned j = 0; j < N_W; j++) begin
        if (widx == WW + 10'(j)) w_q[j] <= wdata;
      end
      for (int unsigned j = 0; j < N_NEURONS; j++) begin
        if (widx == WBias + 10'(j)) bias_q[j] <= wdata;
      end
    end
  end

  // Control/status registers and the MAC sequencer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      i_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      relu_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
      for (int unsigned j = 0; j < N_NEURONS; j++) result_q[j] <= '0;
    end else begin
      if (wr_ok && widx == WCtrl) begin
        relu_en_q <= wbs_dat_i[1];
        irq_en_q  <= wbs_dat_i[2];
      end
      if (wr_ok && widx == WStatus && wbs_dat_i[1]) done_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (wr_ok && widx == WCtrl && wbs_dat_i[0]) begin
            state_q <= StMac;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            i_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= ACC_W'(bias_q[0]);
          end
        end
        StMac: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= k_q + KW'(1);
          if (i_q == IW'(N_INPUTS - 1)) begin
            i_q     <= '0;
            state_q <= StStore;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        StStore: begin
          result_q[n_q] <= (relu_en_q && acc_q[ACC_W-1]) ? '0 : acc_q;
          if (n_q == NW'(N_NEURONS - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            // Placed after the W1C above so a same-cycle set wins.
            done_q  <= 1'b1;
          end else begin
            n_q     <= n_nxt;
            acc_q   <= ACC_W'(bias_q[n_nxt]);
            state_q <= StMac;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign busy_o    = busy_q;
  assign irq_o     = done_q & irq_en_q;

endmodule

// File: tb/tb_wishbone_nn_engine.sv
// Self-checking bench for wishbone_nn_engine: directed steps plus randomized layers,
// all results compared against a plain-arithmetic layer model.
module tb_wishbone_nn_engine;

  localparam int NI = 8;
  localparam int NN = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        irq, busy;

  int n_checks = 0;
  int n_err    = 0;
  int busy_cnt = 0;

  int mx [NI];
  int mw [NI*NN];
  int mb [NN];

  always #5 clk = ~clk;

  // Counts cycles with busy_o high; zeroed by the stimulus only while busy_o is low.
  always @(negedge clk) if (busy) busy_cnt++;

  wishbone_nn_engine dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .irq_o     (irq),
    .busy_o    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer, started at a falling edge; checks ack timing on the way.
  task automatic xfer(input bit w, input logic [11:0] off, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; dat_i = d; adr = BASE | 32'(off);
    #1 chk("ack_before_edge", 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("ack_one_cycle_after", 32'(ack), 32'd1);
    rd = dat_o;
    @(posedge clk); @(negedge clk);
    chk("ack_single_cycle", 32'(ack), 32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
  endtask

  task automatic wr(input logic [11:0] off, input int d);
    logic [31:0] unused_rd;
    xfer(1'b1, off, 32'(d), 4'hF, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, off, '0, 4'hF, r);
    chk(tag, r, exp);
  endtask

  function automatic int model_res(input int n, input bit relu);
    int acc = mb[n];
    for (int i = 0; i < NI; i++) acc += mx[i] * mw[n*NI + i];
    return (relu && acc < 0) ? 0 : acc;
  endfunction

  task automatic load_all();
    for (int i = 0; i < NI; i++)    wr(12'h100 + 12'(4*i), mx[i]);
    for (int k = 0; k < NI*NN; k++) wr(12'h400 + 12'(4*k), mw[k]);
    for (int n = 0; n < NN; n++)    wr(12'h080 + 12'(4*n), mb[n]);
  endtask

  task automatic start(input int ctrl);
    busy_cnt = 0;
    wr(12'h000, ctrl | 1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_results(input string tag, input bit relu);
    for (int n = 0; n < NN; n++) rd_chk(tag, 12'h300 + 12'(4*n), 32'(model_res(n, relu)));
  endtask

  initial begin
    int tmp;
    bit relu;
    rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    for (int i = 0; i < NI; i++) mx[i] = 0;
    for (int k = 0; k < NI*NN; k++) mw[k] = 0;
    for (int n = 0; n < NN; n++) mb[n] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rd_chk("rst_ctrl", 12'h000, 32'd0);
    rd_chk("rst_status", 12'h004, 32'd0);
    rd_chk("rst_result0", 12'h300, 32'd0);

    // Non-hit address is never acked
    stb = 1; cyc = 1; adr = 32'h3000_1000;
    repeat (3) begin @(negedge clk); chk("nohit_ack", 32'(ack), 32'd0); end
    stb = 0; cyc = 0; adr = 0;

    // X = 1..8, W[0][*] = 1, BIAS[0] = 0
    for (int i = 0; i < NI; i++) mx[i] = i + 1;
    for (int i = 0; i < NI; i++) mw[i] = 1;
    load_all();
    start(0);
    wait_idle();
    chk("busy_cycles_basic", 32'(busy_cnt), 32'd36);
    rd_chk("result0_basic", 12'h300, 32'h24);
    rd_chk("status_done", 12'h004, 32'h2);
    rd_chk("x3_readback", 12'h10C, 32'd4);

    // Neuron 1 negative, without and with ReLU
    for (int i = 0; i < NI; i++) begin
      mw[NI + i] = -1;
      wr(12'h400 + 12'(4*(NI + i)), -1);
    end
    mb[1] = -5;
    wr(12'h084, -5);
    rd_chk("bias1_sext", 12'h084, 32'hFFFF_FFFB);
    start(0);
    wait_idle();
    rd_chk("result1_norelu", 12'h304, 32'hFFFF_FFD7);
    check_results("results_norelu", 1'b0);
    start(2);
    wait_idle();
    rd_chk("ctrl_readback", 12'h000, 32'h2);
    rd_chk("result1_relu", 12'h304, 32'd0);
    check_results("results_relu", 1'b1);

    // Extremes with interrupt enabled
    for (int i = 0; i < NI; i++) mx[i] = -128;
    for (int k = 0; k < NI*NN; k++) mw[k] = -128;
    for (int n = 0; n < NN; n++) mb[n] = 127;
    load_all();
    start(4);
    chk("irq_low_while_busy", 32'(irq), 32'd0);
    wait_idle();
    chk("irq_with_done", 32'(irq), 32'd1);
    for (int n = 0; n < NN; n++) rd_chk("result_extreme", 12'h300 + 12'(4*n), 32'h0002_007F);
    wr(12'h004, 2);
    chk("irq_after_w1c", 32'(irq), 32'd0);
    rd_chk("status_after_w1c", 12'h004, 32'd0);

    // Writes during BUSY are acked and ignored; only one run
    start(0);
    wr(12'h100, 99);
    wr(12'h000, 1);
    wait_idle();
    chk("busy_cycles_ignore", 32'(busy_cnt), 32'd36);
    rd_chk("x0_unchanged", 12'h100, 32'(mx[0]));
    check_results("results_busywrite", 1'b0);

    // Partial byte select has no effect
    begin
      logic [31:0] r;
      xfer(1'b1, 12'h104, 32'd5, 4'h3, r);
    end
    rd_chk("x1_sel3", 12'h104, 32'(mx[1]));

    // Randomized layers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) mx[i] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < NI*NN; k++) mw[k] = int'($urandom_range(255)) - 128;
      for (int n = 0; n < NN; n++) mb[n] = int'($urandom_range(255)) - 128;
      relu = 1'($urandom_range(1));
      load_all();
      tmp = int'($urandom_range(NI*NN - 1));
      rd_chk("w_rand_readback", 12'h400 + 12'(4*tmp), 32'(mw[tmp]));
      start(relu ? 2 : 0);
      wait_idle();
      chk("busy_cycles_rand", 32'(busy_cnt), 32'd36);
      check_results("results_rand", relu);
    end

    // Reset in the middle of a computation
    start(0);
    tmp = 0;
    do begin @(negedge clk); #1; tmp++; end while (busy_cnt < 10 && tmp < 100);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) mx[i] = 0;
    for (int k = 0; k < NI*NN; k++) mw[k] = 0;
    for (int n = 0; n < NN; n++) mb[n] = 0;
    rd_chk("midrst_result0", 12'h300, 32'd0);
    rd_chk("midrst_status", 12'h004, 32'd0);
    for (int i = 0; i < NI; i++) begin
      mx[i] = int'($urandom_range(255)) - 128;
      wr(12'h100 + 12'(4*i), mx[i]);
    end
    for (int i = 0; i < NI; i++) begin
      mw[2*NI + i] = int'($urandom_range(255)) - 128;
      wr(12'h400 + 12'(4*(2*NI + i)), mw[2*NI + i]);
    end
    start(0);
    wait_idle();
    chk("busy_cycles_after_rst", 32'(busy_cnt), 32'd36);
    check_results("results_after_rst", 1'b0);
    rd_chk("status_after_rst_run", 12'h004, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
